// File: rtl/sfx_pkg.sv
// Shared types for the sound-effect sequencer: ROM step word layout and FSM states.
package sfx_pkg;

    // Step word, MSB first; the struct layout fixes every field offset and width.
    typedef struct packed {
        logic        last;
        logic [7:0]  dur;
        logic [2:0]  mixer;
        logic [2:0]  lfo_shift;
        logic        noise_sel;
        logic        vco_sel;
        logic [11:0] vco;
        logic [11:0] noise;
        logic [9:0]  lfo;
    } sfx_step_t;

    localparam int unsigned STEP_W = $bits(sfx_step_t);

    localparam logic [2:0] MIXER_SILENT = 3'd0;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StApply,
        StPlay
    } sfx_state_e;

endpackage

// File: rtl/sfx_rom.sv
// Effect step ROM, synchronous read, one word per {id, step} address.
module sfx_rom
    import sfx_pkg::*;
#(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned ADDR_W = 5,
    parameter logic [DEPTH*STEP_W-1:0] ROM_INIT = '0
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    output sfx_step_t         rom_q
);

    // Contents come from the packed init image; word a sits at bits [a*STEP_W +: STEP_W].
    always_ff @(posedge clk) begin
        rom_q <= sfx_step_t'(ROM_INIT[int'(addr)*STEP_W +: STEP_W]);
    end

endmodule

// File: rtl/sfx_sequencer.sv
// Sound-effect sequencer: priority-arbitrates trigger pulses and plays ROM step lists
// into the sound_generator control inputs.
module sfx_sequencer
    import sfx_pkg::*;
#(
    parameter int unsigned NUM_FX = 4,
    parameter int unsigned STEPS_PER_FX = 8,
    parameter int unsigned TICK_DIV = 8192,
    parameter logic [NUM_FX*STEPS_PER_FX*STEP_W-1:0] ROM_INIT = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_FX-1:0]         req,
    output logic                      busy,
    output logic [$clog2(NUM_FX)-1:0] active_id,
    output logic                      done,
    output logic [9:0]                lfo_freq,
    output logic [11:0]               noise_freq,
    output logic [11:0]               vco_freq,
    output logic                      vco_select,
    output logic                      noise_select,
    output logic [2:0]                lfo_shift,
    output logic [2:0]                mixer
);

    localparam int unsigned ID_W = $clog2(NUM_FX);
    localparam int unsigned SW = $clog2(STEPS_PER_FX);
    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [SW-1:0] STEP_LAST = SW'(STEPS_PER_FX - 1);

    sfx_state_e    state;
    logic [SW-1:0] step;
    logic [7:0]    dur_cnt;
    logic          last_q;
    logic [PW-1:0] presc;
    logic          tick;
    logic [ID_W-1:0] win_id;
    logic          accept;
    sfx_step_t     rom_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            presc <= '0;
        end else if (presc == '0) begin
            presc <= PW'(TICK_DIV - 1);
        end else begin
            presc <= presc - 1'b1;
        end
    end

    assign tick = (presc == '0);

    // Highest set request bit wins.
    always_comb begin
        win_id = '0;
        for (int i = 0; i < NUM_FX; i++) begin
            if (req[i]) win_id = ID_W'(i);
        end
    end

    assign accept = (|req) && (state == StIdle || win_id >= active_id);

    sfx_rom #(
        .DEPTH    (NUM_FX * STEPS_PER_FX),
        .ADDR_W   (ID_W + SW),
        .ROM_INIT (ROM_INIT)
    ) u_rom (
        .clk   (clk),
        .addr  ({active_id, step}),
        .rom_q (rom_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= StIdle;
            step         <= '0;
            dur_cnt      <= '0;
            last_q       <= 1'b0;
            active_id    <= '0;
            done         <= 1'b0;
            lfo_freq     <= '0;
            noise_freq   <= '0;
            vco_freq     <= '0;
            vco_select   <= 1'b0;
            noise_select <= 1'b0;
            lfo_shift    <= '0;
            mixer        <= MIXER_SILENT;
        end else begin
            done <= 1'b0;
            // A new accept overrides whatever the FSM would do this cycle, including ending.
            if (accept) begin
                state     <= StFetch;
                active_id <= win_id;
                step      <= '0;
            end else begin
                unique case (state)
                    StIdle: ;
                    StFetch: state <= StApply;
                    StApply: begin
                        lfo_freq     <= rom_q.lfo;
                        noise_freq   <= rom_q.noise;
                        vco_freq     <= rom_q.vco;
                        vco_select   <= rom_q.vco_sel;
                        noise_select <= rom_q.noise_sel;
                        lfo_shift    <= rom_q.lfo_shift;
                        mixer        <= rom_q.mixer;
                        dur_cnt      <= rom_q.dur;
                        last_q       <= rom_q.last;
                        state        <= StPlay;
                    end
                    StPlay: begin
                        if (tick) begin
                            if (dur_cnt != '0) begin
                                dur_cnt <= dur_cnt - 1'b1;
                            end else if (last_q || step == STEP_LAST) begin
                                state <= StIdle;
                                mixer <= MIXER_SILENT;
                                done  <= 1'b1;
                            end else begin
                                step  <= step + 1'b1;
                                state <= StFetch;
                            end
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

    assign busy = (state != StIdle);

endmodule

// File: tb/tb_sfx_sequencer.sv
// Bench for sfx_sequencer: directed scenarios then random triggers, checked every cycle
// against an effect-level timeline model.
module tb_sfx_sequencer;

    localparam int NFX = 4;
    localparam int NST = 8;
    localparam int TDIV = 4;
    localparam int WW = 51;

    function automatic logic [WW-1:0] word(input int fx, input int st);
        int          h;
        logic        last;
        logic [7:0]  dur;
        logic [2:0]  mix;
        logic [2:0]  shf;
        logic [11:0] vco;
        logic [11:0] noi;
        logic [9:0]  lfo;
        h = fx * NST + st;
        case (fx)
            0: begin dur = (st == 0) ? 8'd1 : 8'd2; last = (st == 1); end
            1: begin dur = 8'd12; last = 1'b0; end
            2: begin dur = 8'd3; last = (st == 2); end
            default: begin dur = 8'd0; last = 1'b0; end
        endcase
        mix = 3'(1 + h % 7);
        shf = 3'((h * 5 + 3) % 8);
        vco = 12'((h * 1237 + 901) % 4096);
        noi = 12'((h * 389 + 7) % 4096);
        lfo = 10'((h * 97 + 13) % 1024);
        return {last, dur, mix, shf, h[1], h[0], vco, noi, lfo};
    endfunction

    function automatic logic [NFX*NST*WW-1:0] build_rom();
        logic [NFX*NST*WW-1:0] r;
        r = '0;
        for (int f = 0; f < NFX; f++)
            for (int s = 0; s < NST; s++)
                r[(f * NST + s) * WW +: WW] = word(f, s);
        return r;
    endfunction

    localparam logic [NFX*NST*WW-1:0] TEST_ROM = build_rom();

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = '0;
    logic        busy, done, vco_select, noise_select;
    logic [1:0]  active_id;
    logic [9:0]  lfo_freq;
    logic [11:0] noise_freq, vco_freq;
    logic [2:0]  lfo_shift, mixer;

    sfx_sequencer #(
        .NUM_FX       (NFX),
        .STEPS_PER_FX (NST),
        .TICK_DIV     (TDIV),
        .ROM_INIT     (TEST_ROM)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .busy         (busy),
        .active_id    (active_id),
        .done         (done),
        .lfo_freq     (lfo_freq),
        .noise_freq   (noise_freq),
        .vco_freq     (vco_freq),
        .vco_select   (vco_select),
        .noise_select (noise_select),
        .lfo_shift    (lfo_shift),
        .mixer        (mixer)
    );

    always #5 clk = ~clk;

    // Model: one playing effect, cycles until its next word applies, ticks left in step.
    int          total = 0;
    int          bad = 0;
    int          m_cyc = 0;
    bit          m_busy = 0;
    bit          m_done = 0;
    int          m_id = 0;
    int          m_step = 0;
    int          m_wait = 0;
    int          m_left = 0;
    logic [WW-1:0] m_out = '0;

    task automatic model(input logic [3:0] r, input logic rs);
        bit tick;
        int w;
        logic [WW-1:0] wd;
        if (rs) begin
            m_cyc = 0; m_busy = 0; m_done = 0; m_id = 0; m_step = 0; m_wait = 0;
            m_out = '0;
            return;
        end
        tick = (m_cyc % TDIV) == 0;
        m_cyc++;
        m_done = 0;
        w = 0;
        for (int i = 0; i < NFX; i++) if (r[i]) w = i;
        if (r != 0 && (!m_busy || w >= m_id)) begin
            m_busy = 1; m_id = w; m_step = 0; m_wait = 2;
        end else if (m_busy) begin
            if (m_wait == 2) begin
                m_wait = 1;
            end else if (m_wait == 1) begin
                wd = word(m_id, m_step);
                m_out[WW-10:0] = wd[WW-10:0];
                m_left = int'(wd[49:42]) + 1;
                m_wait = 0;
            end else if (tick) begin
                m_left--;
                if (m_left == 0) begin
                    wd = word(m_id, m_step);
                    if (wd[50] || m_step == NST - 1) begin
                        m_busy = 0; m_done = 1; m_out[41:39] = 3'd0;
                    end else begin
                        m_step++; m_wait = 2;
                    end
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("busy", 32'(busy), 32'(m_busy));
        chk("done", 32'(done), 32'(m_done));
        chk("active_id", 32'(active_id), 32'(m_id));
        chk("lfo_freq", 32'(lfo_freq), 32'(m_out[9:0]));
        chk("noise_freq", 32'(noise_freq), 32'(m_out[21:10]));
        chk("vco_freq", 32'(vco_freq), 32'(m_out[33:22]));
        chk("vco_select", 32'(vco_select), 32'(m_out[34]));
        chk("noise_select", 32'(noise_select), 32'(m_out[35]));
        chk("lfo_shift", 32'(lfo_shift), 32'(m_out[38:36]));
        chk("mixer", 32'(mixer), 32'(m_out[41:39]));
    endtask

    task automatic step(input logic [3:0] r, input logic rs);
        req = r;
        reset = rs;
        @(posedge clk);
        model(r, rs);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(4'b0000, 1'b0);
    endtask

    int dones = 0;
    logic [WW-1:0] w0;

    initial begin
        repeat (3) step(4'b0000, 1'b1);
        idle(2);

        // fx0: outputs appear three cycles after the trigger.
        step(4'b0001, 1'b0);
        idle(2);
        w0 = word(0, 0);
        chk("fx0_cycle3_lfo", 32'(lfo_freq), 32'(w0[9:0]));
        chk("fx0_cycle3_mixer", 32'(mixer), 32'(w0[41:39]));
        for (int i = 0; i < 40; i++) begin
            step(4'b0000, 1'b0);
            if (done) dones++;
        end
        chk("fx0_done_count", 32'(dones), 32'd1);

        // fx1 preempted by fx2; fx2 then ignores a lower-priority fx1 request.
        step(4'b0010, 1'b0);
        idle(20);
        dones = 0;
        step(4'b0100, 1'b0);
        chk("restart_id", 32'(active_id), 32'd2);
        idle(10);
        step(4'b0010, 1'b0);
        chk("drop_keeps_id", 32'(active_id), 32'd2);
        for (int i = 0; i < 80; i++) begin
            step(4'b0000, 1'b0);
            if (done) dones++;
        end
        chk("fx2_done_count", 32'(dones), 32'd1);

        // Simultaneous fx1/fx3: fx3 wins and runs all eight steps.
        step(4'b1010, 1'b0);
        chk("fx3_wins", 32'(active_id), 32'd3);
        idle(90);
        chk("fx3_finished", 32'(busy), 32'd0);

        // Reset during PLAY with a request in the same cycle.
        step(4'b0010, 1'b0);
        idle(8);
        step(4'b0100, 1'b1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_mixer", 32'(mixer), 32'd0);
        idle(3);

        for (int i = 0; i < 4000; i++) begin
            logic [3:0] r;
            logic rs;
            r = ($urandom_range(0, 24) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
            rs = ($urandom_range(0, 700) == 0);
            step(r, rs);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
